// File: rtl/fp_pkg.sv
// Shared definitions for the FP unit's single-precision divider.
// Holds the field widths, the exponent bias, the special-value encodings
// and the divider FSM state type, so the datapath and bench agree on them.
package fp_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int EXP_WIDTH  = 8;
  localparam int MANT_WIDTH = 23;
  localparam int BIAS       = 127;

  // One quotient bit per iteration: hidden bit, 23 fraction bits and one
  // extra bit so a quotient below 1.0 still yields a full mantissa.
  localparam int ITER_COUNT = MANT_WIDTH + 2;
  localparam int CNT_WIDTH  = $clog2(ITER_COUNT);

  // Exponent arithmetic needs a sign bit and one bit of headroom.
  localparam int EXP_CALC_W = EXP_WIDTH + 2;
  localparam int EXP_MAX    = (1 << EXP_WIDTH) - 1;

  localparam logic [DATA_WIDTH-1:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_WIDTH-1:0]  FP_INF_EXP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM
  } div_state_e;

endpackage

// File: rtl/fp_div_seq_mant_div_step.sv
// One restoring-division step on the mantissa datapath.
// Ports:
//   rem_in  - current partial remainder (one bit wider than the divisor)
//   divisor - normalised divisor mantissa {1, fraction}
//   q_bit   - quotient bit produced by this step
//   rem_out - next partial remainder, already shifted left by one
module mant_div_step #(
  parameter int REM_WIDTH = 25
) (
  input  logic [REM_WIDTH-1:0] rem_in,
  input  logic [REM_WIDTH-2:0] divisor,
  output logic                 q_bit,
  output logic [REM_WIDTH-1:0] rem_out
);

  logic [REM_WIDTH-2:0] rem_kept;

  // The remainder always stays below twice the divisor, so after a
  // successful subtraction the difference fits in the divisor width and the
  // top remainder bit only matters for the comparison.
  always_comb begin
    q_bit    = (rem_in >= {1'b0, divisor});
    rem_kept = q_bit ? (rem_in[REM_WIDTH-2:0] - divisor) : rem_in[REM_WIDTH-2:0];
    rem_out  = {rem_kept, 1'b0};
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: out_result = in_numA / in_numB.
// A restoring mantissa divider produces one quotient bit per cycle; results
// are truncated and denormals are flushed to zero.
// Ports:
//   clk, rst    - rising-edge clock, synchronous active-high reset
//   in_start    - operation request, only honoured while idle
//   in_numA/B   - dividend / divisor, captured when the request is accepted
//   out_busy    - high while an operation is in flight
//   out_done    - one-cycle pulse when out_result updates
//   out_result  - quotient, held until the next out_done
module fp_div_seq
  import fp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_start,
  input  logic [DATA_WIDTH-1:0] in_numA,
  input  logic [DATA_WIDTH-1:0] in_numB,
  output logic                  out_busy,
  output logic                  out_done,
  output logic [DATA_WIDTH-1:0] out_result
);

  localparam int REM_W = MANT_WIDTH + 2;
  localparam int DIV_W = MANT_WIDTH + 1;

  div_state_e                   state_q, state_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic [REM_W-1:0]             rem_q, rem_d;
  logic [REM_W-1:0]             quo_q, quo_d;
  logic [DIV_W-1:0]             divisor_q, divisor_d;
  logic                         sign_q, sign_d;
  logic signed [EXP_CALC_W-1:0] exp_q, exp_d;
  logic                         special_q, special_d;
  logic [DATA_WIDTH-1:0]        special_res_q, special_res_d;
  logic [DATA_WIDTH-1:0]        result_q, result_d;
  logic                         done_q, done_d;

  logic [EXP_WIDTH-1:0]         exp_a, exp_b;
  logic                         cap_sign;
  logic                         step_q;
  logic [REM_W-1:0]             step_rem;
  logic signed [EXP_CALC_W-1:0] norm_exp;
  logic [MANT_WIDTH-1:0]        norm_mant;
  logic [DATA_WIDTH-1:0]        norm_res;

  assign exp_a    = in_numA[DATA_WIDTH-2 -: EXP_WIDTH];
  assign exp_b    = in_numB[DATA_WIDTH-2 -: EXP_WIDTH];
  assign cap_sign = in_numA[DATA_WIDTH-1] ^ in_numB[DATA_WIDTH-1];

  mant_div_step #(
    .REM_WIDTH(REM_W)
  ) u_step (
    .rem_in (rem_q),
    .divisor(divisor_q),
    .q_bit  (step_q),
    .rem_out(step_rem)
  );

  // The quotient lies in (0.5, 2): a clear top bit means one more bit of
  // left shift and one less in the exponent. Out-of-range exponents
  // saturate to infinity or flush to zero.
  always_comb begin
    if (quo_q[REM_W-1]) begin
      norm_mant = quo_q[REM_W-2:1];
      norm_exp  = exp_q;
    end else begin
      norm_mant = quo_q[MANT_WIDTH-1:0];
      norm_exp  = exp_q - EXP_CALC_W'(1);
    end
    if (norm_exp >= EXP_CALC_W'(EXP_MAX)) begin
      norm_res = {sign_q, FP_INF_EXP, {MANT_WIDTH{1'b0}}};
    end else if (norm_exp <= EXP_CALC_W'(0)) begin
      norm_res = {sign_q, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      norm_res = {sign_q, norm_exp[EXP_WIDTH-1:0], norm_mant};
    end
  end

  // Next-state logic. Special operands are resolved at capture time and
  // skip the iterations, going straight to NORM with a precomputed result.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    divisor_d     = divisor_q;
    sign_d        = sign_q;
    exp_d         = exp_q;
    special_d     = special_q;
    special_res_d = special_res_q;
    result_d      = result_q;
    done_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_start) begin
          sign_d        = cap_sign;
          exp_d         = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b})
                          + EXP_CALC_W'(BIAS);
          rem_d         = {2'b01, in_numA[MANT_WIDTH-1:0]};
          divisor_d     = {1'b1, in_numB[MANT_WIDTH-1:0]};
          quo_d         = '0;
          cnt_d         = '0;
          special_d     = 1'b1;
          special_res_d = '0;
          if (exp_a == FP_INF_EXP || exp_b == FP_INF_EXP) begin
            special_res_d = FP_QNAN;
          end else if (exp_b == '0) begin
            special_res_d = {cap_sign, FP_INF_EXP, {MANT_WIDTH{1'b0}}};
          end else if (exp_a == '0) begin
            special_res_d = {cap_sign, {(DATA_WIDTH-1){1'b0}}};
          end else begin
            special_d = 1'b0;
          end
          state_d = special_d ? NORM : DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = step_rem;
        quo_d = {quo_q[REM_W-2:0], step_q};
        if (cnt_q == CNT_WIDTH'(ITER_COUNT - 1)) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      NORM: begin
        result_d = special_q ? special_res_q : norm_res;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      divisor_q     <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      result_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      divisor_q     <= divisor_d;
      sign_q        <= sign_d;
      exp_q         <= exp_d;
      special_q     <= special_d;
      special_res_q <= special_res_d;
      result_q      <= result_d;
      done_q        <= done_d;
    end
  end

  assign out_busy   = (state_q != IDLE);
  assign out_done   = done_q;
  assign out_result = result_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed vectors with hand-computed
// results, plus a reference model of the quotient and its timing that is
// compared against the DUT outputs on every cycle.
module tb_fp_div_seq;

  logic        clk;
  logic        rst;
  logic        in_start;
  logic [31:0] in_numA;
  logic [31:0] in_numB;
  logic        out_busy;
  logic        out_done;
  logic [31:0] out_result;

  int passCount;
  int checkCount;
  bit checkEn;

  // Reference model state: cycles remaining until the result appears.
  int          cntM;
  logic [31:0] pendM;
  logic        expDoneM;
  logic [31:0] expResultM;

  fp_div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_start  (in_start),
    .in_numA   (in_numA),
    .in_numB   (in_numB),
    .out_busy  (out_busy),
    .out_done  (out_done),
    .out_result(out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quotient from plain integer division of the mantissas, then truncating
  // normalisation with saturation/flush of the exponent.
  function automatic logic [31:0] modelDiv(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    longint      ma, mb, q;
    logic [22:0] mant;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return 32'h7FC0_0000;
    if (eb == 0) return {s, 8'hFF, 23'h0};
    if (ea == 0) return {s, 31'h0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    q  = (ma << 24) / mb;
    e  = ea - eb + 127;
    if (q >= (longint'(1) << 24)) begin
      mant = 23'(q >> 1);
    end else begin
      mant = 23'(q);
      e    = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), mant};
  endfunction

  function automatic int modelLatency(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF || a[30:23] == 8'h00 || b[30:23] == 8'h00)
      return 1;
    return 26;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Timing model: a request is taken only when nothing is pending; the
  // result and done pulse appear once the latency has elapsed.
  always @(posedge clk) begin
    if (rst) begin
      cntM       <= 0;
      expDoneM   <= 1'b0;
      expResultM <= 32'h0;
    end else begin
      expDoneM <= 1'b0;
      if (cntM != 0) begin
        cntM <= cntM - 1;
        if (cntM == 1) begin
          expDoneM   <= 1'b1;
          expResultM <= pendM;
        end
      end else if (in_start) begin
        pendM <= modelDiv(in_numA, in_numB);
        cntM  <= modelLatency(in_numA, in_numB);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      check("busy", 32'(out_busy), 32'(cntM != 0));
      check("done", 32'(out_done), 32'(expDoneM));
      check("result", out_result, expResultM);
    end
  end

  // Called just after a negedge; returns at the negedge after the start edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    in_numA  = a;
    in_numB  = b;
    in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
  endtask

  // Waits for out_done and checks latency (counted from the start edge)
  // and the result against hand-computed values.
  task automatic checkOutput(input string name, input logic [31:0] expRes,
                             input int expLat, input int already);
    int cycles;
    cycles = already;
    while (!out_done && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_latency"}, 32'(cycles), 32'(expLat));
    check({name, "_value"}, out_result, expRes);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneSeen;
    passCount  = 0;
    checkCount = 0;
    checkEn    = 1'b0;
    rst        = 1'b1;
    in_start   = 1'b0;
    in_numA    = 32'h0;
    in_numB    = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(out_busy), 32'h0);
    check("reset_done", 32'(out_done), 32'h0);
    check("reset_result", out_result, 32'h0);
    rst     = 1'b0;
    checkEn = 1'b1;
    @(negedge clk);

    // 6.0 / 2.0
    applyStimulus(32'h40C0_0000, 32'h4000_0000);
    checkOutput("six_by_two", 32'h4040_0000, 26, 0);
    @(negedge clk);

    // 1.0 / 3.0, then -8.0 / 0.5 requested during the done cycle
    applyStimulus(32'h3F80_0000, 32'h4040_0000);
    checkOutput("one_third", 32'h3EAA_AAAA, 26, 0);
    applyStimulus(32'hC100_0000, 32'h3F00_0000);
    checkOutput("back_to_back", 32'hC180_0000, 26, 0);
    @(negedge clk);

    // Special operands
    applyStimulus(32'h3F80_0000, 32'h0000_0000);
    checkOutput("div_by_zero", 32'h7F80_0000, 1, 0);
    @(negedge clk);
    applyStimulus(32'h0000_0000, 32'h4000_0000);
    checkOutput("zero_dividend", 32'h0000_0000, 1, 0);
    @(negedge clk);
    applyStimulus(32'h7FC0_0000, 32'h3F80_0000);
    checkOutput("nan_operand", 32'h7FC0_0000, 1, 0);
    @(negedge clk);

    // Exponent range
    applyStimulus(32'h7F00_0000, 32'h0080_0000);
    checkOutput("overflow", 32'h7F80_0000, 26, 0);
    @(negedge clk);
    applyStimulus(32'h0080_0000, 32'h7F00_0000);
    checkOutput("underflow", 32'h0000_0000, 26, 0);
    @(negedge clk);

    // Request while busy is ignored
    applyStimulus(32'h40C0_0000, 32'h4000_0000);
    repeat (4) @(negedge clk);
    in_numA  = 32'h3F80_0000;
    in_numB  = 32'h4040_0000;
    in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    checkOutput("ignore_busy", 32'h4040_0000, 26, 5);
    repeat (30) @(negedge clk);
    check("ignore_no_extra_busy", 32'(out_busy), 32'h0);

    // Reset in the middle of an operation
    applyStimulus(32'h3F80_0000, 32'h4040_0000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(out_busy), 32'h0);
    check("abort_result", out_result, 32'h0);
    rst      = 1'b0;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_done) doneSeen++;
    end
    check("abort_no_done", 32'(doneSeen), 32'h0);

    // Recovery after abort
    applyStimulus(32'h3F80_0000, 32'h4040_0000);
    checkOutput("after_reset", 32'h3EAA_AAAA, 26, 0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Sequential IEEE-754 single-precision divider: out_result = in_numA / in_numB.
- It is the inverse-operation companion to the combinational FP multiplier in the FP unit.
- It uses an iterative restoring mantissa divider that produces one quotient bit per cycle, with a start/done handshake.
- It sits in the FP unit beside the multiplier. The FP unit controller issues in_start and waits for out_done.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- EXP_WIDTH, 8, exponent field width.
- MANT_WIDTH, 23, stored mantissa field width. The iteration count is MANT_WIDTH+2 = 25.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_start  input  1  request; sampled only in IDLE.
- in_numA  input  DATA_WIDTH  dividend; captured on the accepted start edge.
- in_numB  input  DATA_WIDTH  divisor; captured on the accepted start edge.
- out_busy  output  1  high while an operation is in flight.
- out_done  output  1  one-cycle pulse when out_result becomes valid.
- out_result  output  DATA_WIDTH  quotient; held until the next out_done.

Behaviour:
- Reset:
  - One clock: synchronous, active-high reset.
  - rst at any edge forces the IDLE state, out_busy=0, out_done=0, out_result=0, and clears all datapath registers.
  - Reset mid-operation aborts the operation with no out_done.
- States and transitions:
  - IDLE: accept a start when in_start=1 (edge T0). Capture sign = A[31]^B[31], the exponents, and mA={1,A[22:0]}, mB={1,B[22:0]}. The remainder register R is loaded with mA (25 bits). Go to DIVIDE, or go to NORM with a special flag.
  - DIVIDE: counter runs 0..24, one step per edge (T1..T25). Each step: q = (R >= mB); if q, R = R - mB; then R = R << 1; shift q into the 25-bit Q register. After the 25th step go to NORM.
  - NORM: one edge (T26). Register out_result, pulse out_done, return to IDLE.
- Latency:
  - Normal case: out_done is high in the cycle following edge T26, i.e. 26 cycles after the start edge.
  - Special case: NORM is reached at T1, so out_done is high 1 cycle after the start edge.
- Handshake and status:
  - out_busy is high from T0+ until the edge that asserts out_done; it is low during the done cycle.
  - in_start while busy is ignored; no queueing.
  - A start in the same cycle as out_done is accepted, because the FSM is back in IDLE at that edge.
- Normalisation (truncate, no rounding):
  - Exponent arithmetic is 10-bit signed: E = eA - eB + 127.
  - If Q[24]=1: mant = Q[23:1], exp = E.
  - Otherwise: mant = Q[22:0], exp = E - 1.
  - exp >= 255 gives signed infinity. exp <= 0 gives signed zero (flush, no denormals).
- Special cases, evaluated at capture in priority order:
  - Either exponent = 255 gives NaN 0x7FC00000.
  - Otherwise, B exponent = 0 (zero or denormal, flushed) gives infinity {sign, 0xFF, 0}.
  - Otherwise, A exponent = 0 gives signed zero {sign, 31'b0}.

Decomposition:
- Shared package fp_pkg holds:
  - width constants DATA_WIDTH/EXP_WIDTH/MANT_WIDTH and BIAS=127;
  - special-value constants FP_QNAN=0x7FC00000, FP_INF_EXP=8'hFF;
  - the FSM state encoding IDLE/DIVIDE/NORM.
- One sub-module, mant_div_step: combinational restoring step. Inputs are R and mB; outputs are q and next R. It is instantiated once in the DIVIDE datapath.

Test Plan:
- Start 0x40C00000 / 0x40000000 -> out_result 0x40400000 (3.0). out_done exactly 26 cycles after the start edge; out_busy high for 26 cycles.
- 0x3F800000 / 0x40400000 -> 0x3EAAAAAA (truncated 1/3). Then 0xC1000000 / 0x3F000000 -> 0xC1800000 (-16.0), issued in the same cycle as the first out_done.
- Special-case results, each 1 cycle after start:
  - 0x3F800000 / 0x00000000 -> 0x7F800000;
  - 0x00000000 / 0x40000000 -> 0x00000000;
  - 0x7FC00000 / 0x3F800000 -> 0x7FC00000.
- Exponent range:
  - 0x7F000000 / 0x00800000 -> overflow, 0x7F800000;
  - 0x00800000 / 0x7F000000 -> underflow, 0x00000000.
- Busy and reset:
  - in_start pulsed at cycle 5 of an operation is ignored, and the first result is unchanged.
  - rst asserted at cycle 10 -> next cycle out_busy=0, out_result=0, and no out_done ever pulses for the aborted operation.
